// File: rtl/reflet_hwi_reader.sv
// Reads the four consecutive hardware-info bytes of a Reflet system over a simple
// read bus and decodes them into clock frequency, word size and peripheral flags.
module reflet_hwi_reader #(
    parameter int                        base_addr_size = 16,
    parameter logic [base_addr_size-1:0] base_addr      = 16'hFF00,
    parameter int                        read_latency   = 1,
    parameter int                        auto_start     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      bus_enable,
    output logic [base_addr_size-1:0] bus_addr,
    input  logic [7:0]                data_in,
    output logic                      busy,
    output logic                      done,
    output logic                      info_valid,
    output logic                      info_error,
    output logic [15:0]               clk_freq_mhz,
    output logic [2:0]                wordsize_code,
    output logic [7:0]                wordsize_bits,
    output logic                      has_exti,
    output logic                      has_gpio,
    output logic                      has_timer,
    output logic                      has_timer2,
    output logic                      has_uart,
    output logic                      has_pwm,
    output logic                      has_segments
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [2:0] LAT     = 3'(read_latency);

    logic [1:0]  r_state;
    logic [1:0]  r_index;
    logic [2:0]  r_count;
    logic        r_pending;
    logic [7:0]  r_byte0;
    logic [7:0]  r_byte1;
    logic [7:0]  r_byte2;
    logic [1:0]  r_byte3;
    logic [15:0] r_freq;
    logic [2:0]  r_code;
    logic [7:0]  r_bits;
    logic        r_valid;
    logic        r_error;
    logic [6:0]  r_flags;

    logic        w_capture;
    logic [7:0]  w_bits;
    logic        w_bad;

    assign w_capture = (r_state == ST_READ) && (r_count == LAT);

    always_comb begin
        w_bits = 8'd0;
        w_bad  = 1'b1;
        case (r_byte2[2:0])
            3'd1: begin w_bits = 8'd8;   w_bad = 1'b0; end
            3'd2: begin w_bits = 8'd16;  w_bad = 1'b0; end
            3'd3: begin w_bits = 8'd32;  w_bad = 1'b0; end
            3'd4: begin w_bits = 8'd64;  w_bad = 1'b0; end
            3'd5: begin w_bits = 8'd128; w_bad = 1'b0; end
            default: begin w_bits = 8'd0; w_bad = 1'b1; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_index   <= 2'd0;
            r_count   <= 3'd0;
            r_pending <= (auto_start != 0);
            r_byte0   <= 8'd0;
            r_byte1   <= 8'd0;
            r_byte2   <= 8'd0;
            r_byte3   <= 2'd0;
            r_freq    <= 16'd0;
            r_code    <= 3'd0;
            r_bits    <= 8'd0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
            r_flags   <= 7'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start || r_pending) begin
                        r_state   <= ST_READ;
                        r_index   <= 2'd0;
                        r_count   <= 3'd0;
                        r_pending <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (w_capture) begin
                        r_count <= 3'd0;
                        case (r_index)
                            2'd0: r_byte0 <= data_in;
                            2'd1: r_byte1 <= data_in;
                            2'd2: r_byte2 <= data_in;
                            2'd3: r_byte3 <= data_in[1:0];
                        endcase
                        if (r_index == 2'd3) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + 2'd1;
                        end
                    end else begin
                        r_count <= r_count + 3'd1;
                    end
                end
                ST_DONE: begin
                    // Decoded view only changes here, so it never shows a half-read set.
                    r_state <= ST_IDLE;
                    r_freq  <= {r_byte1, r_byte0};
                    r_code  <= r_byte2[2:0];
                    r_bits  <= w_bits;
                    r_error <= w_bad;
                    r_valid <= 1'b1;
                    r_flags <= {r_byte3, r_byte2[7:3]};
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus_enable    = (r_state == ST_READ);
    assign bus_addr      = bus_enable ? (base_addr + base_addr_size'(r_index)) : '0;
    assign busy          = (r_state != ST_IDLE);
    assign done          = (r_state == ST_DONE);
    assign info_valid    = r_valid;
    assign info_error    = r_error;
    assign clk_freq_mhz  = r_freq;
    assign wordsize_code = r_code;
    assign wordsize_bits = r_bits;
    assign has_exti      = r_flags[0];
    assign has_gpio      = r_flags[1];
    assign has_timer     = r_flags[2];
    assign has_timer2    = r_flags[3];
    assign has_uart      = r_flags[4];
    assign has_pwm       = r_flags[5];
    assign has_segments  = r_flags[6];

endmodule

// File: tb/tb_reflet_hwi_reader.sv
// Bench for reflet_hwi_reader: three parameterisations driven by a latency-aware
// bus responder, checked against a decode model built from the field rules.
module tb_reflet_hwi_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        start [3];
    logic        en    [3];
    logic [15:0] addr  [3];
    logic [7:0]  din   [3] = '{8'h5A, 8'h5A, 8'h5A};
    logic        busy  [3];
    logic        done  [3];
    logic        iv    [3];
    logic        ie    [3];
    logic [15:0] freq  [3];
    logic [2:0]  code  [3];
    logic [7:0]  wsb   [3];
    logic [6:0]  fl    [3];

    logic [7:0]  resp  [3][4];
    int          hold      [3] = '{0, 0, 0};
    logic        prev_en   [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] prev_addr [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] alog      [3][64];
    int          alog_n    [3] = '{0, 0, 0};
    int          en_cnt    [3] = '{0, 0, 0};
    int          done_cnt  [3] = '{0, 0, 0};
    logic [15:0] off_v;

    int tests = 0;
    int fails = 0;
    int s_en, s_done, s_alog;

`define HWI_INST(NAME, K, BASE, LATV, AUTO) \
    reflet_hwi_reader #(.base_addr_size(16), .base_addr(BASE), .read_latency(LATV), .auto_start(AUTO)) NAME ( \
        .clk(clk), .reset(rst_n[K]), .start(start[K]), .bus_enable(en[K]), .bus_addr(addr[K]), \
        .data_in(din[K]), .busy(busy[K]), .done(done[K]), .info_valid(iv[K]), .info_error(ie[K]), \
        .clk_freq_mhz(freq[K]), .wordsize_code(code[K]), .wordsize_bits(wsb[K]), \
        .has_exti(fl[K][0]), .has_gpio(fl[K][1]), .has_timer(fl[K][2]), .has_timer2(fl[K][3]), \
        .has_uart(fl[K][4]), .has_pwm(fl[K][5]), .has_segments(fl[K][6]));

    `HWI_INST(u_a, 0, 16'hFF00, 1, 1)
    `HWI_INST(u_b, 1, 16'hFFFE, 0, 0)
    `HWI_INST(u_c, 2, 16'hFF00, 2, 0)

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 0 : 2;
    endfunction

    function automatic logic [15:0] base_of(input int k);
        return (k == 1) ? 16'hFFFE : 16'hFF00;
    endfunction

    // Responder: a byte is only correct once its address has been held read_latency cycles.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (en[k] && prev_en[k] && addr[k] == prev_addr[k]) hold[k] = hold[k] + 1;
            else hold[k] = 0;
            if (en[k] && hold[k] == 0) begin
                if (alog_n[k] < 64) alog[k][alog_n[k]] = addr[k];
                alog_n[k] = alog_n[k] + 1;
            end
            if (en[k]) en_cnt[k] = en_cnt[k] + 1;
            if (done[k]) done_cnt[k] = done_cnt[k] + 1;
            off_v = addr[k] - base_of(k);
            if (!en[k]) din[k] = 8'h5A;
            else if (off_v > 16'd3) din[k] = 8'hA5;
            else if (hold[k] == lat_of(k)) din[k] = resp[k][off_v[1:0]];
            else din[k] = ~resp[k][off_v[1:0]];
            prev_en[k] = en[k];
            prev_addr[k] = addr[k];
        end
    end

    // {info_valid, info_error, clk_freq_mhz, wordsize_code, wordsize_bits, flags}
    function automatic logic [35:0] exp_info(input logic [7:0] b0, b1, b2, b3);
        int          c;
        logic        err;
        logic [7:0]  bits;
        logic [6:0]  flags;
        c     = int'(b2[2:0]);
        err   = !(c >= 1 && c <= 5);
        bits  = err ? 8'd0 : 8'(1 << (c + 2));
        flags = {b3[1], b3[0], b2[7], b2[6], b2[5], b2[4], b2[3]};
        return {1'b1, err, b1, b0, b2[2:0], bits, flags};
    endfunction

    function automatic logic [35:0] act_info(input int k);
        return {iv[k], ie[k], freq[k], code[k], wsb[k], fl[k]};
    endfunction

    function automatic logic [54:0] act_all(input int k);
        return {busy[k], done[k], en[k], addr[k], act_info(k)};
    endfunction

    function automatic logic [63:0] addr_seq(input int k, input int from);
        return {alog[k][from], alog[k][from+1], alog[k][from+2], alog[k][from+3]};
    endfunction

    task automatic snap(input int k);
        s_en = en_cnt[k];
        s_done = done_cnt[k];
        s_alog = alog_n[k];
    endtask

    task automatic wait_done(input int k, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done[k]) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Pulse start for one edge, then count edges until done; cyc excludes the accept edge.
    task automatic run_seq(input int k, output int cyc);
        @(posedge clk); #1;
        snap(k);
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        wait_done(k, 60, cyc);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        #12;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (act_all(k) !== 55'd0) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: got %h expected 0", k, act_all(k));
            end
        end
        @(negedge clk);
        rst_n[1] = 1'b1;
        rst_n[2] = 1'b1;
        snap(1);
        repeat (6) @(posedge clk);
        #1;
        tests++;
        if (busy[1] !== 1'b0 || en_cnt[1] !== s_en || busy[2] !== 1'b0) begin
            fails++;
            $display("FAIL no_auto_start: got busy_b=%b busy_c=%b en_cycles=%0d expected 0 0 0",
                     busy[1], busy[2], en_cnt[1] - s_en);
        end
    endtask

    task automatic test_auto_start;
        int cyc;
        logic [35:0] exp;
        resp[0] = '{8'h32, 8'h00, 8'hFA, 8'h03};
        exp = exp_info(8'h32, 8'h00, 8'hFA, 8'h03);
        @(negedge clk);
        snap(0);
        rst_n[0] = 1'b1;
        wait_done(0, 30, cyc);
        tests++;
        if (cyc != 9) begin
            fails++;
            $display("FAIL auto_done_cycle: got %0d expected 9", cyc);
        end
        @(posedge clk); #1;
        tests++;
        if (act_info(0) !== exp || freq[0] !== 16'd50 || wsb[0] !== 8'd16 || fl[0] !== 7'h7F) begin
            fails++;
            $display("FAIL auto_decode: got %h expected %h", act_info(0), exp);
        end
        tests++;
        if (alog_n[0] - s_alog != 4 || addr_seq(0, s_alog) !== 64'hFF00_FF01_FF02_FF03 || en_cnt[0] - s_en != 8) begin
            fails++;
            $display("FAIL auto_addr_seq: got %h (%0d en cycles) expected ff00ff01ff02ff03 (8)",
                     addr_seq(0, s_alog), en_cnt[0] - s_en);
        end
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (done_cnt[0] - s_done != 1) begin
            fails++;
            $display("FAIL auto_once: got %0d done pulses expected 1", done_cnt[0] - s_done);
        end
    endtask

    task automatic test_start_pulse;
        int cyc;
        logic [35:0] exp;
        resp[1] = '{8'hE8, 8'h03, 8'h03, 8'h01};
        exp = exp_info(8'hE8, 8'h03, 8'h03, 8'h01);
        run_seq(1, cyc);
        tests++;
        if (cyc != 4) begin
            fails++;
            $display("FAIL pulse_done_cycle: got %0d expected 4", cyc);
        end
        tests++;
        if (act_info(1) !== exp || freq[1] !== 16'd1000 || wsb[1] !== 8'd32 || fl[1] !== 7'b0100000) begin
            fails++;
            $display("FAIL pulse_decode: got %h expected %h", act_info(1), exp);
        end
        tests++;
        if (alog_n[1] - s_alog != 4 || addr_seq(1, s_alog) !== 64'hFFFE_FFFF_0000_0001 || en_cnt[1] - s_en != 4) begin
            fails++;
            $display("FAIL wrap_addr_seq: got %h (%0d en cycles) expected fffeffff00000001 (4)",
                     addr_seq(1, s_alog), en_cnt[1] - s_en);
        end
    endtask

    task automatic test_wordsize_error;
        int cyc;
        resp[1] = '{8'h10, 8'h00, 8'h06, 8'h00};
        run_seq(1, cyc);
        tests++;
        if ({ie[1], wsb[1], iv[1]} !== {1'b1, 8'd0, 1'b1} || cyc != 4) begin
            fails++;
            $display("FAIL ws_error: got ie=%b bits=%0d valid=%b cyc=%0d expected 1 0 1 4", ie[1], wsb[1], iv[1], cyc);
        end
        resp[1][2] = 8'h01;
        run_seq(1, cyc);
        tests++;
        if ({ie[1], wsb[1], iv[1]} !== {1'b0, 8'd8, 1'b1} || cyc != 4) begin
            fails++;
            $display("FAIL ws_ok: got ie=%b bits=%0d valid=%b cyc=%0d expected 0 8 1 4", ie[1], wsb[1], iv[1], cyc);
        end
    endtask

    // Random bytes, random start noise while busy, and a start in the DONE cycle.
    task automatic test_random;
        logic [35:0] prev;
        logic [35:0] exp;
        int          cyc;
        int          held_bad;
        prev = act_info(2);
        for (int n = 0; n < 6; n++) begin
            for (int b = 0; b < 4; b++) resp[2][b] = 8'($urandom);
            exp = exp_info(resp[2][0], resp[2][1], resp[2][2], resp[2][3]);
            held_bad = 0;
            cyc = -1;
            @(posedge clk); #1;
            snap(2);
            start[2] = 1'b1;
            for (int i = 1; i <= 40; i++) begin
                @(posedge clk); #1;
                if (done[2]) begin
                    cyc = i;
                    start[2] = 1'b1;
                    @(posedge clk); #1;
                    start[2] = 1'b0;
                    break;
                end
                if (act_info(2) !== prev) held_bad++;
                start[2] = 1'($urandom_range(0, 1));
            end
            start[2] = 1'b0;
            tests++;
            if (cyc != 13 || busy[2] !== 1'b0) begin
                fails++;
                $display("FAIL rand_timing[%0d]: got done at %0d busy_after=%b expected 13 0", n, cyc, busy[2]);
            end
            tests++;
            if (act_info(2) !== exp) begin
                fails++;
                $display("FAIL rand_decode[%0d]: got %h expected %h", n, act_info(2), exp);
            end
            tests++;
            if (held_bad != 0 || en_cnt[2] - s_en != 12 || done_cnt[2] - s_done != 1) begin
                fails++;
                $display("FAIL rand_hold[%0d]: got %0d changes %0d en %0d done expected 0 12 1",
                         n, held_bad, en_cnt[2] - s_en, done_cnt[2] - s_done);
            end
            prev = exp;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        snap(2);
        start[2] = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(posedge clk); #1;
            if (busy[2] !== (((k - 1) % 14) < 13)) bad++;
        end
        start[2] = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL b2b_busy_pattern: got %0d wrong cycles expected 0", bad);
        end
        tests++;
        if (done_cnt[2] - s_done != 3 || en_cnt[2] - s_en != 36) begin
            fails++;
            $display("FAIL b2b_counts: got %0d done %0d en expected 3 36", done_cnt[2] - s_done, en_cnt[2] - s_en);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid;
        int found;
        int cyc;
        logic [35:0] exp;
        found = 0;
        for (int b = 0; b < 4; b++) resp[0][b] = 8'($urandom);
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (en[0] && addr[0] == 16'hFF02) begin
                found = 1;
                break;
            end
        end
        #1;
        rst_n[0] = 1'b0;
        #1;
        tests++;
        if (found == 0 || act_all(0) !== 55'd0) begin
            fails++;
            $display("FAIL reset_mid_async: got %h (index2 seen=%0d) expected 0", act_all(0), found);
        end
        for (int b = 0; b < 4; b++) resp[0][b] = 8'($urandom);
        exp = exp_info(resp[0][0], resp[0][1], resp[0][2], resp[0][3]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        snap(0);
        rst_n[0] = 1'b1;
        wait_done(0, 30, cyc);
        @(posedge clk); #1;
        tests++;
        if (cyc != 9 || act_info(0) !== exp) begin
            fails++;
            $display("FAIL reset_mid_rerun: got cyc=%0d info=%h expected 9 %h", cyc, act_info(0), exp);
        end
        tests++;
        if (alog_n[0] - s_alog != 4 || addr_seq(0, s_alog) !== 64'hFF00_FF01_FF02_FF03) begin
            fails++;
            $display("FAIL reset_mid_addr: got %h expected ff00ff01ff02ff03", addr_seq(0, s_alog));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            start[k] = 1'b0;
            for (int b = 0; b < 4; b++) resp[k][b] = 8'h00;
        end
        test_reset();
        test_auto_start();
        test_start_pulse();
        test_wordsize_error();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
